// File: rtl/cpu_sram_arbiter_pkg.sv
// rtl/cpu_sram_arbiter_pkg.sv - shared encodings for the CPU SRAM-like port arbiter
package cpu_sram_arbiter_pkg;

  typedef enum logic {
    ARB_FREE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_e;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

endpackage

// File: rtl/cpu_sram_arbiter_owner_fifo.sv
// rtl/cpu_sram_arbiter_owner_fifo.sv - in-order 1-bit owner FIFO for outstanding transactions
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] L_FULL_CNT = (AW + 1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == L_FULL_CNT);
  assign empty  = (r_count == '0);
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Full is taken from the registered count, so a same-cycle pop never frees room for a push.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_mem    <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - round-robin arbiter sharing one SRAM-like port between inst and data
module cpu_sram_arbiter
  import cpu_sram_arbiter_pkg::*;
#(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_orphan
);

  arb_state_e r_state;
  logic       r_held_sel;
  logic       r_last_grant;
  logic       r_err_orphan;

  logic w_free_sel;
  logic w_sel_data;
  logic w_sel_req;
  logic w_grant;
  logic w_pop;
  logic w_head;
  logic w_full;
  logic w_empty;

  // Data wins a tie unless it was the last side granted.
  assign w_free_sel = data_req && (!inst_req || r_last_grant == OWNER_INST);
  assign w_sel_data = (r_state == ARB_HOLD) ? r_held_sel : w_free_sel;
  assign w_sel_req  = w_sel_data ? data_req : inst_req;

  assign mem_req   = resetn && w_sel_req && !w_full;
  assign mem_wr    = w_sel_data ? data_wr    : inst_wr;
  assign mem_size  = w_sel_data ? data_size  : inst_size;
  assign mem_addr  = w_sel_data ? data_addr  : inst_addr;
  assign mem_wstrb = w_sel_data ? data_wstrb : inst_wstrb;
  assign mem_wdata = w_sel_data ? data_wdata : inst_wdata;

  assign w_grant      = mem_req && mem_addr_ok;
  assign data_addr_ok = w_grant && w_sel_data;
  assign inst_addr_ok = w_grant && !w_sel_data;

  assign w_pop        = resetn && mem_data_ok && !w_empty;
  assign data_data_ok = w_pop && (w_head == OWNER_DATA);
  assign inst_data_ok = w_pop && (w_head == OWNER_INST);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;
  assign err_orphan   = r_err_orphan;

  owner_fifo #(
    .DEPTH (MAX_OUT)
  ) u_owner_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (w_grant),
    .pop    (w_pop),
    .din    (w_sel_data),
    .dout   (w_head),
    .full   (w_full),
    .empty  (w_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ARB_FREE;
      r_held_sel   <= OWNER_INST;
      r_last_grant <= OWNER_INST;
    end else begin
      case (r_state)
        ARB_FREE: begin
          if (mem_req && !mem_addr_ok) begin
            r_state    <= ARB_HOLD;
            r_held_sel <= w_sel_data;
          end
        end
        ARB_HOLD: begin
          if (w_grant) r_state <= ARB_FREE;
        end
        default: r_state <= ARB_FREE;
      endcase
      if (w_grant) r_last_grant <= w_sel_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err_orphan <= 1'b0;
    end else if (mem_data_ok && w_empty) begin
      r_err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb/tb_cpu_sram_arbiter.sv - scoreboard bench for cpu_sram_arbiter
module tb_cpu_sram_arbiter;

  localparam logic OW_I = 1'b0;
  localparam logic OW_D = 1'b1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        mem_addr_ok, mem_data_ok;
  logic        err_orphan;

  typedef struct {
    int          cyc;
    logic        owner;
    logic        wr;
    logic [31:0] val;
  } exp_t;

  exp_t q_g[$];
  exp_t q_r[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  cpu_sram_arbiter #(.MAX_OUT(2)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_g(input logic owner, input logic wr, input logic [31:0] addr);
    q_g.push_back('{cyc, owner, wr, addr});
  endtask

  task automatic exp_r(input logic owner, input logic [31:0] val);
    q_r.push_back('{cyc, owner, 1'b0, val});
  endtask

  task automatic set_inst(input logic req, input logic [31:0] addr);
    inst_req = req; inst_wr = 1'b0; inst_size = 2'b10; inst_addr = addr;
    inst_wstrb = 4'h0; inst_wdata = 32'h0;
  endtask

  task automatic set_data(input logic req, input logic wr, input logic [31:0] addr);
    data_req = req; data_wr = wr; data_size = 2'b10; data_addr = addr;
    data_wstrb = wr ? 4'hF : 4'h0; data_wdata = addr ^ 32'h5A5A_5A5A;
  endtask

  // Address-phase monitor
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (inst_addr_ok || data_addr_ok) begin
        n_tests++;
        if (q_g.size() == 0) begin
          n_fail++;
          $display("FAIL grant_unexpected: inst_addr_ok=%b data_addr_ok=%b addr=%h cycle %0d",
                   inst_addr_ok, data_addr_ok, mem_addr, cyc);
        end else begin
          exp_t e;
          e = q_g.pop_front();
          if (e.cyc != cyc || data_addr_ok !== e.owner || (inst_addr_ok && data_addr_ok) ||
              mem_addr !== e.val || mem_wr !== e.wr) begin
            n_fail++;
            $display("FAIL grant: got cyc=%0d owner=%b wr=%b addr=%h, want cyc=%0d owner=%b wr=%b addr=%h",
                     cyc, data_addr_ok, mem_wr, mem_addr, e.cyc, e.owner, e.wr, e.val);
          end
        end
      end else if (q_g.size() > 0 && q_g[0].cyc <= cyc) begin
        exp_t e;
        e = q_g.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL grant_missing: got no addr_ok, want owner=%b addr=%h at cycle %0d",
                 e.owner, e.val, e.cyc);
      end
    end
  end

  // Return-path monitor
  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (inst_data_ok || data_data_ok) begin
        n_tests++;
        if (q_r.size() == 0) begin
          n_fail++;
          $display("FAIL return_unexpected: inst_data_ok=%b data_data_ok=%b cycle %0d",
                   inst_data_ok, data_data_ok, cyc);
        end else begin
          exp_t        e;
          logic [31:0] rd;
          e  = q_r.pop_front();
          rd = data_data_ok ? data_rdata : inst_rdata;
          if (e.cyc != cyc || data_data_ok !== e.owner || (inst_data_ok && data_data_ok) ||
              rd !== e.val) begin
            n_fail++;
            $display("FAIL return: got cyc=%0d owner=%b rdata=%h, want cyc=%0d owner=%b rdata=%h",
                     cyc, data_data_ok, rd, e.cyc, e.owner, e.val);
          end
        end
      end else if (q_r.size() > 0 && q_r[0].cyc <= cyc) begin
        exp_t e;
        e = q_r.pop_front();
        n_tests++;
        n_fail++;
        $display("FAIL return_missing: got no data_ok, want owner=%b rdata=%h at cycle %0d",
                 e.owner, e.val, e.cyc);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},      mem_req,      0);
    chk({tag, "_inst_addr_ok"}, inst_addr_ok, 0);
    chk({tag, "_data_addr_ok"}, data_addr_ok, 0);
    chk({tag, "_inst_data_ok"}, inst_data_ok, 0);
    chk({tag, "_data_data_ok"}, data_data_ok, 0);
  endtask

  initial begin
    resetn = 1'b0;
    set_inst(0, 32'h0);
    set_data(0, 0, 32'h0);
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state with every input pushing
    set_inst(1, 32'h1111_0000); set_data(1, 0, 32'h2222_0000);
    mem_addr_ok = 1'b1; mem_data_ok = 1'b1;
    @(negedge clk);
    chk_all_zero("reset");
    chk("reset_err_orphan", err_orphan, 0);
    next(); resetn = 1'b1;
    set_inst(0, 32'h0); set_data(0, 0, 32'h0); mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    next();

    // Single instruction fetch
    set_inst(1, 32'hBFC0_0000); mem_addr_ok = 1'b1; exp_g(OW_I, 0, 32'hBFC0_0000);
    @(negedge clk); chk("t1_mem_addr", mem_addr, 32'hBFC0_0000);
    next(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h2408_0001; exp_r(OW_I, 32'h2408_0001);
    next(); mem_data_ok = 1'b0;

    // Round-robin alternation with back-to-back returns
    set_data(1, 0, 32'h8000_0100); set_inst(1, 32'hBFC0_0100); mem_addr_ok = 1'b1;
    exp_g(OW_D, 0, 32'h8000_0100);
    next(); set_data(1, 1, 32'h8000_0104); exp_g(OW_I, 0, 32'hBFC0_0100);
    mem_data_ok = 1'b1; mem_rdata = 32'hA000_0000; exp_r(OW_D, 32'hA000_0000);
    next(); set_inst(1, 32'hBFC0_0104); exp_g(OW_D, 1, 32'h8000_0104);
    mem_rdata = 32'hA000_0001; exp_r(OW_I, 32'hA000_0001);
    next(); set_data(1, 0, 32'h8000_0108); exp_g(OW_I, 0, 32'hBFC0_0104);
    mem_rdata = 32'hA000_0002; exp_r(OW_D, 32'hA000_0002);
    next(); inst_req = 1'b0; exp_g(OW_D, 0, 32'h8000_0108);
    mem_rdata = 32'hA000_0003; exp_r(OW_I, 32'hA000_0003);
    next(); data_req = 1'b0; mem_addr_ok = 1'b0;
    mem_rdata = 32'hA000_0004; exp_r(OW_D, 32'hA000_0004);
    next(); mem_data_ok = 1'b0;

    // Held selection: inst (which would win round-robin) must not preempt
    set_data(1, 0, 32'h8000_0200);
    @(negedge clk); chk("hold_addr_c1", mem_addr, 32'h8000_0200);
    next(); set_inst(1, 32'hBFC0_0200);
    @(negedge clk); chk("hold_addr_c2", mem_addr, 32'h8000_0200);
    next();
    @(negedge clk); chk("hold_addr_c3", mem_addr, 32'h8000_0200);
    next(); mem_addr_ok = 1'b1; exp_g(OW_D, 0, 32'h8000_0200);
    next(); data_req = 1'b0; exp_g(OW_I, 0, 32'hBFC0_0200);
    next(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hB000_0005; exp_r(OW_D, 32'hB000_0005);
    next(); mem_rdata = 32'hB000_0006; exp_r(OW_I, 32'hB000_0006);
    next(); mem_data_ok = 1'b0;

    // Full FIFO blocks, a pop re-enables the push one cycle later
    set_inst(1, 32'hBFC0_0300); mem_addr_ok = 1'b1; exp_g(OW_I, 0, 32'hBFC0_0300);
    next(); inst_req = 1'b0; set_data(1, 0, 32'h8000_0300); exp_g(OW_D, 0, 32'h8000_0300);
    next(); data_req = 1'b0; set_inst(1, 32'hBFC0_0304);
    @(negedge clk); chk("full_mem_req", mem_req, 0);
    next(); mem_data_ok = 1'b1; mem_rdata = 32'hC000_0007; exp_r(OW_I, 32'hC000_0007);
    @(negedge clk); chk("full_pop_mem_req", mem_req, 0);
    next(); mem_data_ok = 1'b0; exp_g(OW_I, 0, 32'hBFC0_0304);
    next(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'hC000_0008; exp_r(OW_D, 32'hC000_0008);
    next(); mem_rdata = 32'hC000_0009; exp_r(OW_I, 32'hC000_0009);
    next(); mem_data_ok = 1'b0;

    // Orphan return is flagged and sticky until reset
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); chk("orphan_before", err_orphan, 0);
    next(); mem_data_ok = 1'b0;
    @(negedge clk); chk("orphan_set", err_orphan, 1);
    next();
    @(negedge clk); chk("orphan_sticky", err_orphan, 1);
    next(); resetn = 1'b0;
    @(negedge clk); chk("orphan_reset", err_orphan, 0);
    next(); resetn = 1'b1;

    // Reset with two outstanding discards ownership; data wins the first tie after
    next(); set_inst(1, 32'hBFC0_0400); mem_addr_ok = 1'b1; exp_g(OW_I, 0, 32'hBFC0_0400);
    next(); inst_req = 1'b0; set_data(1, 0, 32'h8000_0400); exp_g(OW_D, 0, 32'h8000_0400);
    next(); resetn = 1'b0; set_inst(1, 32'hBFC0_0500); set_data(1, 0, 32'h8000_0500);
    mem_data_ok = 1'b1; mem_rdata = 32'hEEEE_0000;
    @(negedge clk); chk_all_zero("midreset");
    next(); resetn = 1'b1; mem_data_ok = 1'b0; exp_g(OW_D, 0, 32'h8000_0500);
    next(); data_req = 1'b0; exp_g(OW_I, 0, 32'hBFC0_0500);
    mem_data_ok = 1'b1; mem_rdata = 32'hE000_000A; exp_r(OW_D, 32'hE000_000A);
    next(); inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_rdata = 32'hE000_000B; exp_r(OW_I, 32'hE000_000B);
    next(); mem_data_ok = 1'b0;
    @(negedge clk); chk("post_reset_err_orphan", err_orphan, 0);
    repeat (3) next();

    chk("grant_queue_drained", q_g.size(), 0);
    chk("return_queue_drained", q_r.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
